apb_axi_bridge: RTL and testbench

APB4 completer that converts each APB transfer into a single AXI4-Lite master transaction, the reverse direction of the AXI4-Lite-to-APB path already in the design. It sits on an APB segment as one of the requester's slaves and forwards accesses that fall inside its address window onto an AXI4-Lite fabric. Out-of-window accesses are rejected locally with PSLVERR and generate no AXI traffic. There is one transaction in flight at a time; there is no buffering beyond the captured request.

---
 rtl/apb_axi_bridge.sv | 245 ++++++++++++++++++++++++
 tb/tb_apb_axi_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_axi_bridge.sv
// -----------------------------------------------------------------------------
// apb_axi_bridge
//
// APB4 completer that forwards each in-window APB transfer as one AXI4-Lite
// master transaction. Accesses outside [Base_Address, Base_Address+memory_size)
// complete locally with PSLVERR and produce no AXI traffic. Only one request is
// held at a time. All outputs are driven directly from flops.
//
// Ports:
//   m_axi_clk, m_axi_areset        single clock, synchronous active-high reset
//   s_apb_*                        APB4 completer interface
//                                  (psel/penable/pwrite/paddr/pwdata/pstrb/pprot in,
//                                   pready/prdata/pslverr out)
//   m_axi_aw*/w*/b*                AXI4-Lite write address, data and response
//   m_axi_ar*/r*                   AXI4-Lite read address and data
// -----------------------------------------------------------------------------
module apb_axi_bridge #(
  parameter logic [31:0] Base_Address = 32'h0000_0000,
  parameter int unsigned memory_size  = 1024
) (
  input  logic        m_axi_clk,
  input  logic        m_axi_areset,

  input  logic        s_apb_psel,
  input  logic        s_apb_penable,
  input  logic        s_apb_pwrite,
  input  logic [31:0] s_apb_paddr,
  input  logic [31:0] s_apb_pwdata,
  input  logic [3:0]  s_apb_pstrb,
  input  logic [2:0]  s_apb_pprot,
  output logic        s_apb_pready,
  output logic [31:0] s_apb_prdata,
  output logic        s_apb_pslverr,

  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,

  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,

  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,

  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,

  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  state_t      state_q, state_d;

  logic [31:0] addr_q, addr_d;
  logic [2:0]  prot_q, prot_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        pready_q, pready_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pslverr_q, pslverr_d;

  logic        setup_phase;
  logic [31:0] addr_offset;
  logic        in_window;
  logic        aw_done;
  logic        w_done;
  logic        unused_resp_lsb;

  assign setup_phase = s_apb_psel && !s_apb_penable;

  // Offset form avoids overflow of Base_Address + memory_size near the top of
  // the address space.
  assign addr_offset = s_apb_paddr - Base_Address;
  assign in_window   = (s_apb_paddr >= Base_Address) && (addr_offset < memory_size);

  // A channel counts as finished if it already handshook in an earlier cycle
  // (valid already dropped) or is handshaking in this one.
  assign aw_done = !awvalid_q || m_axi_awready;
  assign w_done  = !wvalid_q  || m_axi_wready;

  // Only the upper response bit distinguishes error from success.
  assign unused_resp_lsb = m_axi_bresp[0] ^ m_axi_rresp[0];

  always_ff @(posedge m_axi_clk) begin
    if (m_axi_areset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      prot_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      prot_q    <= prot_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  // Next-state logic computes the value every output register must hold in
  // the following cycle, so the APB response is latched on entry to DONE.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    prot_d    = prot_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = 1'b0;
    rready_d  = 1'b0;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (setup_phase) begin
          addr_d  = s_apb_paddr;
          prot_d  = s_apb_pprot;
          wdata_d = s_apb_pwdata;
          wstrb_d = s_apb_pstrb;
          if (!in_window) begin
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else if (s_apb_pwrite) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end

      WR_REQ: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end

      WR_RESP: begin
        bready_d = 1'b1;
        if (m_axi_bvalid) begin
          state_d   = DONE;
          bready_d  = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = m_axi_bresp[1];
        end
      end

      RD_REQ: begin
        if (m_axi_arready) begin
          state_d   = RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end

      RD_RESP: begin
        rready_d = 1'b1;
        if (m_axi_rvalid) begin
          state_d   = DONE;
          rready_d  = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = m_axi_rresp[1];
          prdata_d  = m_axi_rresp[1] ? '0 : m_axi_rdata;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s_apb_pready  = pready_q;
  assign s_apb_prdata  = prdata_q;
  assign s_apb_pslverr = pslverr_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = prot_q;
  assign m_axi_awvalid = awvalid_q;

  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;

  assign m_axi_bready  = bready_q;

  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = prot_q;
  assign m_axi_arvalid = arvalid_q;

  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_apb_axi_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_axi_bridge
//
// Directed bench for apb_axi_bridge. The bench plays both the APB requester and
// a cycle-driven AXI4-Lite slave. Expected APB responses (data, error, latency
// in cycles from the setup edge) are queued when a transfer is issued and
// compared when pready is seen.
// -----------------------------------------------------------------------------
module tb_apb_axi_bridge;

  logic        m_axi_clk = 1'b0;
  logic        m_axi_areset;
  logic        s_apb_psel, s_apb_penable, s_apb_pwrite;
  logic [31:0] s_apb_paddr, s_apb_pwdata;
  logic [3:0]  s_apb_pstrb;
  logic [2:0]  s_apb_pprot;
  logic        s_apb_pready;
  logic [31:0] s_apb_prdata;
  logic        s_apb_pslverr;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid, m_axi_rready;

  apb_axi_bridge #(
    .Base_Address(32'h0000_0000),
    .memory_size (1024)
  ) dut (
    .m_axi_clk     (m_axi_clk),
    .m_axi_areset  (m_axi_areset),
    .s_apb_psel    (s_apb_psel),
    .s_apb_penable (s_apb_penable),
    .s_apb_pwrite  (s_apb_pwrite),
    .s_apb_paddr   (s_apb_paddr),
    .s_apb_pwdata  (s_apb_pwdata),
    .s_apb_pstrb   (s_apb_pstrb),
    .s_apb_pprot   (s_apb_pprot),
    .s_apb_pready  (s_apb_pready),
    .s_apb_prdata  (s_apb_prdata),
    .s_apb_pslverr (s_apb_pslverr),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  always #5 m_axi_clk = ~m_axi_clk;

  typedef struct {
    logic [31:0] prdata;
    logic        slverr;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge m_axi_clk);
    #1;
  endtask

  task automatic clear_axi();
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    m_axi_rvalid  = 1'b0;
    m_axi_rresp   = 2'b00;
    m_axi_rdata   = 32'h0;
  endtask

  function automatic logic any_output();
    return |{s_apb_pready, s_apb_prdata, s_apb_pslverr,
             m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
             m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
             m_axi_araddr, m_axi_arprot, m_axi_arvalid, m_axi_rready};
  endfunction

  // One APB transfer. aw_rdy/w_rdy/ar_rdy: first access-phase cycle (1-based)
  // in which the slave raises that ready; rsp_lat: idle cycles between the last
  // request handshake and the response valid.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [2:0] prot,
                      input int aw_rdy, input int w_rdy, input int ar_rdy, input int rsp_lat,
                      input logic [1:0] resp, input logic [31:0] rdat, input string tag);
    exp_t e, got;
    bit   in_win, done, aw_h, w_h, ar_h, any_v;
    int   c, rsp_cyc, b_cnt, r_cnt;

    in_win = (addr < 32'd1024);
    if (!in_win)  e = '{32'h0, 1'b1, 1};
    else if (wr)  e = '{32'h0, resp[1], ((aw_rdy > w_rdy) ? aw_rdy : w_rdy) + rsp_lat + 2};
    else          e = '{(resp[1] ? 32'h0 : rdat), resp[1], ar_rdy + rsp_lat + 2};
    sb.push_back(e);

    s_apb_psel = 1'b1; s_apb_penable = 1'b0; s_apb_pwrite = wr;
    s_apb_paddr = addr; s_apb_pwdata = data; s_apb_pstrb = strb; s_apb_pprot = prot;
    tick();
    // Access phase: scramble the request fields; the bridge must use its capture.
    s_apb_penable = 1'b1; s_apb_pwrite = ~wr;
    s_apb_paddr = ~addr; s_apb_pwdata = ~data; s_apb_pstrb = ~strb; s_apb_pprot = ~prot;

    c = 1; done = 0; aw_h = 0; w_h = 0; ar_h = 0; any_v = 0;
    rsp_cyc = 0; b_cnt = 0; r_cnt = 0;
    while (!done && c <= 60) begin
      clear_axi();
      any_v = any_v | m_axi_awvalid | m_axi_wvalid | m_axi_arvalid;
      if (s_apb_pready) begin
        got = sb.pop_front();
        chk({tag, "_prdata"},  s_apb_prdata,  got.prdata);
        chk({tag, "_pslverr"}, s_apb_pslverr, got.slverr);
        chk({tag, "_latency"}, c,             got.lat);
        done = 1;
      end else if (wr && in_win) begin
        chk({tag, "_awvalid"}, m_axi_awvalid, !aw_h);
        chk({tag, "_wvalid"},  m_axi_wvalid,  !w_h);
        if (!aw_h && c >= aw_rdy) begin
          m_axi_awready = 1'b1;
          if (m_axi_awvalid) begin
            chk({tag, "_awaddr"}, m_axi_awaddr, addr);
            chk({tag, "_awprot"}, m_axi_awprot, prot);
            aw_h = 1;
          end
        end
        if (!w_h && c >= w_rdy) begin
          m_axi_wready = 1'b1;
          if (m_axi_wvalid) begin
            chk({tag, "_wdata"}, m_axi_wdata, data);
            chk({tag, "_wstrb"}, m_axi_wstrb, strb);
            w_h = 1;
          end
        end
        if (aw_h && w_h && rsp_cyc == 0) rsp_cyc = c + 1 + rsp_lat;
        if (rsp_cyc != 0 && c >= rsp_cyc && b_cnt == 0) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = resp;
          if (m_axi_bready) b_cnt++;
        end
      end else if (!wr && in_win) begin
        chk({tag, "_arvalid"}, m_axi_arvalid, !ar_h);
        if (!ar_h && c >= ar_rdy) begin
          m_axi_arready = 1'b1;
          if (m_axi_arvalid) begin
            chk({tag, "_araddr"}, m_axi_araddr, addr);
            chk({tag, "_arprot"}, m_axi_arprot, prot);
            ar_h = 1;
            rsp_cyc = c + 1 + rsp_lat;
          end
        end
        if (rsp_cyc != 0 && c >= rsp_cyc && r_cnt == 0) begin
          m_axi_rvalid = 1'b1;
          m_axi_rresp  = resp;
          m_axi_rdata  = rdat;
          if (m_axi_rready) r_cnt++;
        end
      end
      if (!done) begin
        tick();
        c++;
      end
    end
    chk({tag, "_pready_seen"}, done, 1'b1);
    if (!done) got = sb.pop_front();

    clear_axi();
    s_apb_psel = 1'b0; s_apb_penable = 1'b0;
    chk({tag, "_b_count"},   b_cnt, (wr && in_win) ? 1 : 0);
    chk({tag, "_r_count"},   r_cnt, (!wr && in_win) ? 1 : 0);
    chk({tag, "_axi_valid"}, any_v, in_win);
    tick();
    chk({tag, "_pready_1cyc"}, s_apb_pready,  1'b0);
    chk({tag, "_prdata_idle"}, s_apb_prdata,  32'h0);
    chk({tag, "_slverr_idle"}, s_apb_pslverr, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1);
  end

  initial begin
    m_axi_areset  = 1'b1;
    s_apb_psel    = 1'b0; s_apb_penable = 1'b0; s_apb_pwrite = 1'b0;
    s_apb_paddr   = 32'h0; s_apb_pwdata = 32'h0; s_apb_pstrb = 4'h0; s_apb_pprot = 3'h0;
    clear_axi();
    tick();
    tick();
    chk("reset_outputs", any_output(), 1'b0);
    m_axi_areset = 1'b0;
    tick();

    // Zero-wait write / read with stalls
    xfer(1, 32'h0000_0010, 32'hA5A5_1234, 4'hF, 3'b010, 1, 1, 0, 0, 2'b00, 32'h0, "wr_basic");
    xfer(0, 32'h0000_03FC, 32'h0,         4'h0, 3'b001, 0, 0, 4, 0, 2'b00, 32'hDEAD_BEEF, "rd_arwait");
    // Independent AW / W handshake order
    xfer(1, 32'h0000_0020, 32'h1111_2222, 4'h3, 3'b000, 3, 1, 0, 0, 2'b00, 32'h0, "wr_w_first");
    xfer(1, 32'h0000_0024, 32'h3333_4444, 4'hC, 3'b100, 1, 3, 0, 0, 2'b00, 32'h0, "wr_aw_first");
    xfer(1, 32'h0000_0028, 32'h5555_6666, 4'h5, 3'b011, 2, 2, 0, 2, 2'b00, 32'h0, "wr_slow_b");
    // Out-of-window, both directions
    xfer(0, 32'h0000_0400, 32'h0,         4'h0, 3'b000, 0, 0, 0, 0, 2'b00, 32'h0, "rd_oow");
    xfer(1, 32'h8000_0000, 32'h7777_8888, 4'hF, 3'b000, 0, 0, 0, 0, 2'b00, 32'h0, "wr_oow");
    // Response mapping
    xfer(0, 32'h0000_0100, 32'h0,         4'h0, 3'b000, 0, 0, 1, 0, 2'b10, 32'h1234_5678, "rd_slverr");
    xfer(1, 32'h0000_0104, 32'h9999_AAAA, 4'hF, 3'b000, 1, 1, 0, 0, 2'b11, 32'h0, "wr_decerr");
    xfer(0, 32'h0000_0108, 32'h0,         4'h0, 3'b000, 0, 0, 1, 1, 2'b01, 32'hCAFE_F00D, "rd_exokay");
    // Zero strobes still forwarded
    xfer(1, 32'h0000_0000, 32'hBBBB_CCCC, 4'h0, 3'b111, 1, 1, 0, 0, 2'b00, 32'h0, "wr_strb0");

    // Reset while waiting for the write response
    s_apb_psel = 1'b1; s_apb_penable = 1'b0; s_apb_pwrite = 1'b1;
    s_apb_paddr = 32'h0000_0040; s_apb_pwdata = 32'hFEED_0001; s_apb_pstrb = 4'hF; s_apb_pprot = 3'b000;
    tick();
    s_apb_penable = 1'b1;
    chk("rst_mid_awvalid", m_axi_awvalid, 1'b1);
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    tick();
    clear_axi();
    chk("rst_mid_bready", m_axi_bready, 1'b1);
    m_axi_areset = 1'b1;
    tick();
    chk("rst_mid_outputs", any_output(), 1'b0);
    m_axi_areset = 1'b0;
    s_apb_psel = 1'b0; s_apb_penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid_no_pready", s_apb_pready, 1'b0);
      tick();
    end
    xfer(0, 32'h0000_0044, 32'h0, 4'h0, 3'b010, 0, 0, 1, 0, 2'b00, 32'h0BAD_CAFE, "rd_after_rst");

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
